ifu_fetch: RTL

//   Instruction fetch unit for the npc-riscv64 core; sits directly upstream of the decode stage.

---
 rtl/ifu_pkg.sv | 6 +
 rtl/ifu_fetch.sv | 93 +++++++++
 2 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding and constants for the instruction fetch unit
package ifu_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC register, single-outstanding imem fetch FSM and decode-facing holding register
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst_pc;
  logic [31:0]     r_inst;
  logic            r_flush;
  logic            r_stale;
  logic            r_inst_valid;
  logic            r_inst_fault;
  logic            w_mis;
  logic            w_req;
  logic            w_fire;
  logic            w_wait_resp;
  logic            w_out;
  // r_flush marks a response still owed for a request whose PC was redirected away
  assign w_mis       = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_req       = (r_state == S_REQ) && !rst && !r_flush && !w_mis;
  assign w_fire      = w_req && imem_req_ready;
  assign w_wait_resp = (r_state == S_WAIT) && imem_resp_valid;
  assign w_out       = ((r_state == S_WAIT) && !imem_resp_valid) || w_fire || (r_flush && !imem_resp_valid);
  assign imem_req_valid = w_req;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign inst_fault     = r_inst_fault;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_flush      <= 1'b0;
      r_stale      <= 1'b1;
      r_inst_valid <= 1'b0;
      r_inst       <= INST_NOP;
      r_inst_pc    <= '0;
      r_inst_fault <= 1'b0;
    end else begin
      if (w_fire) r_stale <= 1'b0;
      if (redirect_valid) begin
        r_pc         <= redirect_pc;
        r_flush      <= w_out;
        r_inst_valid <= w_mis;
        r_state      <= w_mis ? S_HOLD : (w_out ? S_WAIT : S_REQ);
        if (w_mis) begin
          r_inst       <= INST_NOP;
          r_inst_pc    <= redirect_pc;
          r_inst_fault <= 1'b1;
        end
      end else begin
        if (w_fire) r_state <= S_WAIT;
        if (imem_resp_valid && r_flush) r_flush <= 1'b0;
        if (w_wait_resp && r_flush) r_state <= S_REQ;
        if (w_wait_resp && !r_flush) begin
          r_inst       <= imem_resp_err ? INST_NOP : imem_resp_data;
          r_inst_pc    <= r_pc;
          r_inst_fault <= imem_resp_err;
          r_inst_valid <= 1'b1;
          r_pc         <= r_pc + XLEN'(4);
          r_state      <= S_HOLD;
        end
        if ((r_state == S_HOLD) && inst_ready) begin
          r_inst_valid <= 1'b0;
          r_state      <= r_inst_fault ? S_HALT : S_REQ;
        end
      end
    end
  end
  // a response is legal only when one is owed: in S_WAIT, after a redirect, or left over from before reset
  a_resp_owed: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> ((r_state == S_WAIT) || r_flush || r_stale));
endmodule
